// File: rtl/timing_gen.sv
// Beat / machine-cycle timing generator for the teaching CPU.
// Emits one-hot T strobes nested inside one-hot W strobes, with run/stop, single-step and stall.
module timing_gen #(
   parameter int NUM_T = 4,
   parameter int NUM_W = 2,
   parameter int CNT_W = 16,
   localparam int LEN_W  = $clog2(NUM_W + 1),
   localparam int BEAT_W = (NUM_T > 1) ? $clog2(NUM_T) : 1,
   localparam int MCYC_W = (NUM_W > 1) ? $clog2(NUM_W) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              step_mode,
   input  logic              stall,
   input  logic [LEN_W-1:0]  cyc_len,
   output logic [NUM_T-1:0]  t,
   output logic [NUM_W-1:0]  w,
   output logic [BEAT_W-1:0] beat,
   output logic [MCYC_W-1:0] mcyc,
   output logic              running,
   output logic              instr_end,
   output logic [CNT_W-1:0]  instr_cnt
);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e            state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [MCYC_W-1:0] mcyc_q, mcyc_d;
   logic [LEN_W-1:0]  ncyc_q, ncyc_d;
   logic              stopPend_q, stopPend_d;
   logic [CNT_W-1:0]  instrCnt_q, instrCnt_d;

   logic lastBeat;
   logic lastMcyc;
   logic instrEnd;

   // A zero-length instruction still needs one machine cycle; oversize lengths saturate.
   function automatic logic [LEN_W-1:0] clampLen(input logic [LEN_W-1:0] len);
      logic [LEN_W-1:0] res;
      res = len;
      if (len == '0) begin
         res = LEN_W'(1);
      end else if (len > LEN_W'(NUM_W)) begin
         res = LEN_W'(NUM_W);
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         mcyc_q     <= '0;
         ncyc_q     <= LEN_W'(1);
         stopPend_q <= 1'b0;
         instrCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         mcyc_q     <= mcyc_d;
         ncyc_q     <= ncyc_d;
         stopPend_q <= stopPend_d;
         instrCnt_q <= instrCnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      mcyc_d     = mcyc_q;
      ncyc_d     = ncyc_q;
      stopPend_d = stopPend_q;
      instrCnt_d = instrCnt_q;

      lastBeat = (beat_q == BEAT_W'(NUM_T - 1));
      lastMcyc = (LEN_W'(mcyc_q) == (ncyc_q - LEN_W'(1)));
      instrEnd = (state_q == RUN) && !stall && lastBeat && lastMcyc;

      case (state_q)
         IDLE: begin
            stopPend_d = 1'b0;
            if (start && !stop) begin
               state_d = RUN;
               beat_d  = '0;
               mcyc_d  = '0;
               ncyc_d  = clampLen(cyc_len);
            end
         end
         RUN: begin
            // A stop request is remembered even while stalled and only honoured at the boundary.
            if (stop && !instrEnd) begin
               stopPend_d = 1'b1;
            end
            if (instrEnd) begin
               instrCnt_d = instrCnt_q + CNT_W'(1);
               beat_d     = '0;
               mcyc_d     = '0;
               ncyc_d     = clampLen(cyc_len);
               if (stopPend_q || stop || step_mode) begin
                  state_d    = IDLE;
                  stopPend_d = 1'b0;
               end
            end else if (!stall) begin
               if (!lastBeat) begin
                  beat_d = beat_q + BEAT_W'(1);
               end else begin
                  beat_d = '0;
                  mcyc_d = mcyc_q + MCYC_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobes decode straight from the counters, so a stall holds them automatically.
   always_comb begin
      t = '0;
      w = '0;
      for (int i = 0; i < NUM_T; i++) begin
         t[NUM_T-1-i] = (state_q == RUN) && (beat_q == BEAT_W'(i));
      end
      for (int i = 0; i < NUM_W; i++) begin
         w[NUM_W-1-i] = (state_q == RUN) && (mcyc_q == MCYC_W'(i));
      end
   end

   assign beat      = beat_q;
   assign mcyc      = mcyc_q;
   assign running   = (state_q == RUN);
   assign instr_end = instrEnd;
   assign instr_cnt = instrCnt_q;

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen: default 4x2 instance, a 5x3 instance and a 2-bit counter instance
// share one stimulus stream.
module tb_timing_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       step_mode;
   logic       stall;
   logic [1:0] cyc_len;

   logic [3:0]  t0;
   logic [1:0]  w0;
   logic [1:0]  beat0;
   logic [0:0]  mcyc0;
   logic        run0, end0;
   logic [15:0] cnt0;

   logic [4:0]  t1;
   logic [2:0]  w1;
   logic [2:0]  beat1;
   logic [1:0]  mcyc1;
   logic        run1, end1;
   logic [15:0] cnt1;

   logic [3:0]  t2;
   logic [1:0]  w2;
   logic [1:0]  beat2;
   logic [0:0]  mcyc2;
   logic        run2, end2;
   logic [1:0]  cnt2;

   int nChecks = 0;
   int nBad    = 0;

   int eb, em, en, ec;

   timing_gen #(.NUM_T(4), .NUM_W(2), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode), .stall(stall),
      .cyc_len(cyc_len), .t(t0), .w(w0), .beat(beat0), .mcyc(mcyc0), .running(run0),
      .instr_end(end0), .instr_cnt(cnt0)
   );

   timing_gen #(.NUM_T(5), .NUM_W(3), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode), .stall(stall),
      .cyc_len(cyc_len), .t(t1), .w(w1), .beat(beat1), .mcyc(mcyc1), .running(run1),
      .instr_end(end1), .instr_cnt(cnt1)
   );

   timing_gen #(.NUM_T(4), .NUM_W(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .step_mode(step_mode), .stall(stall),
      .cyc_len(cyc_len), .t(t2), .w(w2), .beat(beat2), .mcyc(mcyc2), .running(run2),
      .instr_end(end2), .instr_cnt(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nBad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic waitPos();
      @(posedge clk);
      #1;
   endtask

   task automatic waitNeg();
      @(negedge clk);
   endtask

   function automatic int clampLen(input int v);
      if (v == 0) return 1;
      if (v > 2) return 2;
      return v;
   endfunction

   task automatic applyReset();
      rst       = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      stall     = 1'b0;
      step_mode = 1'b0;
      waitPos();
      waitPos();
      rst = 1'b1;
      eb = 0; em = 0; en = 1; ec = 0;
   endtask

   task automatic applyStimulus();
      start = 1'b1;
      waitPos();
      start = 1'b0;
      eb = 0;
      em = 0;
      en = clampLen(int'(cyc_len));
   endtask

   // Walks the 4x2 instance for n cycles against the expected beat/cycle position.
   task automatic runBeats(input int n);
      bit endE;
      for (int k = 0; k < n; k++) begin
         waitNeg();
         endE = (eb == 3) && (em == en - 1);
         checkOutput("t", 32'(t0), 32'(8 >> eb));
         checkOutput("w", 32'(w0), 32'(2 >> em));
         checkOutput("running", 32'(run0), 32'd1);
         checkOutput("instr_end", 32'(end0), 32'(endE));
         checkOutput("beat", 32'(beat0), 32'(eb));
         checkOutput("mcyc", 32'(mcyc0), 32'(em));
         checkOutput("instr_cnt", 32'(cnt0), 32'(ec));
         checkOutput("instr_cnt2", 32'(cnt2), 32'(ec % 4));
         waitPos();
         if (endE) begin
            ec = ec + 1;
            eb = 0;
            em = 0;
            en = clampLen(int'(cyc_len));
         end else if (eb == 3) begin
            eb = 0;
            em = em + 1;
         end else begin
            eb = eb + 1;
         end
      end
   endtask

   task automatic checkIdle(input string tag);
      waitNeg();
      checkOutput({tag, "_t"}, 32'(t0), 32'd0);
      checkOutput({tag, "_w"}, 32'(w0), 32'd0);
      checkOutput({tag, "_running"}, 32'(run0), 32'd0);
      checkOutput({tag, "_end"}, 32'(end0), 32'd0);
      checkOutput({tag, "_cnt"}, 32'(cnt0), 32'(ec));
      waitPos();
   endtask

   initial begin
      cyc_len = 2'd2;
      applyReset();
      checkIdle("reset");
      checkOutput("reset_beat", 32'(beat0), 32'd0);
      checkOutput("reset_mcyc", 32'(mcyc0), 32'd0);

      // start together with stop must not leave IDLE
      start = 1'b1;
      stop  = 1'b1;
      waitPos();
      start = 1'b0;
      stop  = 1'b0;
      checkIdle("startstop");

      // free run: three 8-cycle instructions
      cyc_len = 2'd2;
      applyStimulus();
      runBeats(24);
      checkOutput("cnt_after24", 32'(cnt0), 32'd3);

      // stall at beat 1 of W1 for three cycles
      runBeats(1);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         waitNeg();
         checkOutput("stall_t", 32'(t0), 32'h4);
         checkOutput("stall_w", 32'(w0), 32'h2);
         checkOutput("stall_end", 32'(end0), 32'd0);
         checkOutput("stall_beat", 32'(beat0), 32'd1);
         waitPos();
      end
      stall = 1'b0;
      runBeats(7);

      // stall on the final beat suppresses instr_end
      runBeats(7);
      stall = 1'b1;
      waitNeg();
      checkOutput("stall_last_t", 32'(t0), 32'h1);
      checkOutput("stall_last_w", 32'(w0), 32'h1);
      checkOutput("stall_last_end", 32'(end0), 32'd0);
      waitPos();
      stall = 1'b0;
      runBeats(1);
      checkOutput("cnt_after_stall", 32'(cnt0), 32'd5);

      // stop at beat 1 of W1 lets the instruction finish
      runBeats(1);
      stop = 1'b1;
      runBeats(1);
      stop = 1'b0;
      runBeats(6);
      checkIdle("stopped");
      checkOutput("stop_cnt", 32'(cnt0), 32'd6);

      // single-step, one machine cycle per instruction
      applyReset();
      step_mode = 1'b1;
      cyc_len   = 2'd1;
      applyStimulus();
      runBeats(4);
      checkIdle("step1");
      applyStimulus();
      runBeats(4);
      checkIdle("step2");
      checkOutput("step_cnt", 32'(cnt0), 32'd2);

      // length clamping
      cyc_len = 2'd0;
      applyStimulus();
      runBeats(4);
      checkIdle("len0");
      cyc_len = 2'd3;
      applyStimulus();
      runBeats(8);
      checkIdle("len3");
      checkOutput("clamp_cnt", 32'(cnt0), 32'd4);

      // 2-bit counter wrap, then reset in the middle of an instruction
      applyReset();
      step_mode = 1'b0;
      cyc_len   = 2'd1;
      applyStimulus();
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) cyc_len = 2'd2;
         runBeats(4);
         checkOutput("cnt2_seq", 32'(cnt2), 32'(k % 4));
      end
      runBeats(6);
      checkOutput("pre_rst_beat", 32'(beat0), 32'd2);
      checkOutput("pre_rst_mcyc", 32'(mcyc0), 32'd1);
      rst = 1'b0;
      waitPos();
      checkOutput("midrst_t", 32'(t0), 32'd0);
      checkOutput("midrst_w", 32'(w0), 32'd0);
      checkOutput("midrst_running", 32'(run0), 32'd0);
      checkOutput("midrst_end", 32'(end0), 32'd0);
      checkOutput("midrst_cnt", 32'(cnt0), 32'd0);
      checkOutput("midrst_cnt2", 32'(cnt2), 32'd0);
      checkOutput("midrst_beat", 32'(beat0), 32'd0);
      checkOutput("midrst_mcyc", 32'(mcyc0), 32'd0);
      rst = 1'b1;

      // 5-beat, 3-cycle configuration
      applyReset();
      cyc_len = 2'd3;
      applyStimulus();
      for (int i = 0; i < 30; i++) begin
         waitNeg();
         checkOutput("t53", 32'(t1), 32'(16 >> (i % 5)));
         checkOutput("w53", 32'(w1), 32'(4 >> ((i / 5) % 3)));
         checkOutput("end53", 32'(end1), 32'((i % 15) == 14));
         checkOutput("run53", 32'(run1), 32'd1);
         waitPos();
      end
      checkOutput("cnt53", 32'(cnt1), 32'd2);

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

endmodule
